eship_sched_follower: RTL and testbench

Per-ship consumer of the enemy movement schedule. Each cycle it watches the schedule counter. On every counter change it applies that step's signed X/Y delta to the ship position, clamps the result to the play field, and raises a fire request when that step is flagged. It also owns the ship's life cycle: spawn, active, explode, dead. One instance sits beside each enemy sprite, between the enemy scheduler and the sprite/projectile logic.

---
 rtl/galaga_lib.sv | 22 ++
 rtl/eship_sched_follower_fire_ctrl.sv | 58 +++++
 rtl/eship_sched_follower.sv | 151 +++++++++++++++
 tb/tb_eship_sched_follower.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/galaga_lib.sv
// Shared constants, ship life-cycle states and the schedule step clamp for the enemy-ship blocks.
package galaga_lib;
  localparam int SCHED_NM    = 20;
  localparam int NUM_ENEMIES = 8;

  localparam logic [9:0] SCR_XMIN = 10'd0;
  localparam logic [9:0] SCR_XMAX = 10'd620;
  localparam logic [9:0] SCR_YMIN = 10'd0;
  localparam logic [9:0] SCR_YMAX = 10'd460;

  typedef enum logic [1:0] {SPAWN, ACTIVE, EXPLODE, DEAD} ship_state_t;

  // Position is an unsigned screen coordinate; only the delta carries a sign.
  function automatic logic [9:0] step_clamp(input logic [9:0] pos, input logic [9:0] delta,
                                            input logic [9:0] lo, input logic [9:0] hi);
    logic signed [11:0] sum;
    sum = $signed({2'b00, pos}) + $signed({{2{delta[9]}}, delta});
    if (sum < $signed({2'b00, lo})) return lo;
    if (sum > $signed({2'b00, hi})) return hi;
    return sum[9:0];
  endfunction
endpackage

// File: rtl/eship_sched_follower_fire_ctrl.sv
// eship_fire_ctrl: fire cooldown, FireReq/FireAck handshake and launch-position latch.
module eship_fire_ctrl
  import galaga_lib::*;
#(
  parameter int FIRE_COOLDOWN = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       fire_i,
  input  logic       kill_i,
  input  logic       ack_i,
  input  logic [9:0] x_i,
  input  logic [9:0] y_i,
  output logic       req_o,
  output logic [9:0] x_o,
  output logic [9:0] y_o
);
  localparam int CW = $clog2(FIRE_COOLDOWN + 1);

  logic [CW-1:0] cd_q, cd_d;
  logic          req_q, req_d;
  logic [9:0]    x_q, x_d, y_q, y_d;

  always_comb begin
    cd_d  = (cd_q != '0) ? cd_q - CW'(1) : cd_q;
    req_d = ack_i ? 1'b0 : req_q;
    x_d   = x_q;
    y_d   = y_q;
    // A flagged step during cooldown is simply dropped.
    if (fire_i && cd_q == '0) begin
      req_d = 1'b1;
      x_d   = x_i;
      y_d   = y_i;
      cd_d  = CW'(FIRE_COOLDOWN);
    end
    if (kill_i) req_d = 1'b0;
    if (clr_i)  cd_d  = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cd_q  <= '0;
      req_q <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      cd_q  <= cd_d;
      req_q <= req_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign req_o = req_q;
  assign x_o   = x_q;
  assign y_o   = y_q;
endmodule

// File: rtl/eship_sched_follower.sv
// Per-ship schedule follower: applies each new schedule step to the ship position and runs the
// spawn/active/explode/dead life cycle. Define ESHIP_RESPAWN_EN to let DEAD return to SPAWN.
module eship_sched_follower
  import galaga_lib::*;
#(
  parameter int         NM             = SCHED_NM,
  parameter logic [9:0] XMIN           = SCR_XMIN,
  parameter logic [9:0] XMAX           = SCR_XMAX,
  parameter logic [9:0] YMIN           = SCR_YMIN,
  parameter logic [9:0] YMAX           = SCR_YMAX,
  parameter int         EXPLODE_CYCLES = 32,
  parameter int         FIRE_COOLDOWN  = 64,
  parameter int         RESPAWN_CYCLES = 1024
) (
  input  logic                Clk_i,
  input  logic                Reset_i,
  input  logic [9:0]          ESchedCtr_i,
  input  logic [NM-1:0][9:0]  SchedX_i,
  input  logic [NM-1:0][9:0]  SchedY_i,
  input  logic [NM-1:0]       SchedFire_i,
  input  logic [9:0]          InitialX_i,
  input  logic [9:0]          InitialY_i,
  input  logic                Hit_i,
  input  logic                FireAck_i,
  output logic                FireReq_o,
  output logic [9:0]          FireX_o,
  output logic [9:0]          FireY_o,
  output logic [9:0]          ShipX_o,
  output logic [9:0]          ShipY_o,
  output logic                Alive_o,
  output logic                Exploding_o
);
  localparam int EW = $clog2(EXPLODE_CYCLES + 1);

  if (RESPAWN_CYCLES < 1) begin : g_bad_respawn
    $error("RESPAWN_CYCLES must be at least 1");
  end

  ship_state_t   state_q, state_d;
  logic [9:0]    x_q, x_d, y_q, y_d, ctr_q, ctr_d;
  logic [EW-1:0] ex_q, ex_d;
  logic [9:0]    dx, dy;
  logic          sfire, step, hit, fire;
`ifdef ESHIP_RESPAWN_EN
  localparam int RW = $clog2(RESPAWN_CYCLES + 1);
  logic [RW-1:0] resp_q, resp_d;
`endif

  // Out-of-range counter values fall through as a zero delta with no fire.
  always_comb begin
    dx    = '0;
    dy    = '0;
    sfire = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (ESchedCtr_i == 10'(i)) begin
        dx    = SchedX_i[i];
        dy    = SchedY_i[i];
        sfire = SchedFire_i[i];
      end
    end
  end

  assign hit  = (state_q == ACTIVE) && Hit_i;
  assign step = (state_q == ACTIVE) && (ESchedCtr_i != ctr_q) && !Hit_i;
  assign fire = step && sfire;

  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_q <= SPAWN;
      x_q     <= '0;
      y_q     <= '0;
      ctr_q   <= '0;
      ex_q    <= '0;
`ifdef ESHIP_RESPAWN_EN
      resp_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ctr_q   <= ctr_d;
      ex_q    <= ex_d;
`ifdef ESHIP_RESPAWN_EN
      resp_q  <= resp_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ex_d    = '0;
`ifdef ESHIP_RESPAWN_EN
    resp_d  = '0;
`endif
    case (state_q)
      SPAWN:   state_d = ACTIVE;
      ACTIVE:  if (Hit_i) state_d = EXPLODE;
      EXPLODE: begin
        ex_d = ex_q + EW'(1);
        if (ex_q == EW'(EXPLODE_CYCLES - 1)) state_d = DEAD;
      end
      DEAD: begin
`ifdef ESHIP_RESPAWN_EN
        resp_d = resp_q + RW'(1);
        if (resp_q == RW'(RESPAWN_CYCLES - 1)) state_d = SPAWN;
`endif
      end
      default: state_d = SPAWN;
    endcase
  end

  // SPAWN snapshots the counter so the value present on entry is not applied as a step.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    ctr_d = ctr_q;
    if (state_q == SPAWN) begin
      x_d   = InitialX_i;
      y_d   = InitialY_i;
      ctr_d = ESchedCtr_i;
    end else if (state_q == ACTIVE) begin
      ctr_d = ESchedCtr_i;
      if (step) begin
        x_d = step_clamp(x_q, dx, XMIN, XMAX);
        y_d = step_clamp(y_q, dy, YMIN, YMAX);
      end
    end
  end

  always_comb begin
    Alive_o     = (state_q == ACTIVE);
    Exploding_o = (state_q == EXPLODE);
  end

  assign ShipX_o = x_q;
  assign ShipY_o = y_q;

  eship_fire_ctrl #(.FIRE_COOLDOWN(FIRE_COOLDOWN)) u_fire (
    .clk_i  (Clk_i),
    .rst_i  (Reset_i),
    .clr_i  (state_q == SPAWN),
    .fire_i (fire),
    .kill_i (hit),
    .ack_i  (FireAck_i),
    .x_i    (x_d),
    .y_i    (y_d),
    .req_o  (FireReq_o),
    .x_o    (FireX_o),
    .y_o    (FireY_o)
  );
endmodule

// File: tb/tb_eship_sched_follower.sv
// Directed bench for eship_sched_follower with a cycle-level life-cycle model and literal spot checks.
module tb_eship_sched_follower;
  localparam int NM = 20;
  localparam int XMIN = 0, XMAX = 620, YMIN = 0, YMAX = 460;
  localparam int EXPLODE_CYCLES = 32, FIRE_COOLDOWN = 64, RESPAWN_CYCLES = 1024;

  logic                Clk = 1'b0;
  logic                Reset, Hit, FireAck;
  logic [9:0]          ESchedCtr, InitialX, InitialY;
  logic [NM-1:0][9:0]  SchedX, SchedY;
  logic [NM-1:0]       SchedFire;
  logic                FireReq, Alive, Exploding;
  logic [9:0]          FireX, FireY, ShipX, ShipY;

  int  t_dx[NM], t_dy[NM];
  bit  t_f[NM];
  int  n_vec = 0, n_err = 0;
  bit  chk_en = 1'b0;

  always #5 Clk = ~Clk;

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      SchedX[i]    = 10'(t_dx[i]);
      SchedY[i]    = 10'(t_dy[i]);
      SchedFire[i] = t_f[i];
    end
  end

  eship_sched_follower dut (
    .Clk_i(Clk), .Reset_i(Reset), .ESchedCtr_i(ESchedCtr),
    .SchedX_i(SchedX), .SchedY_i(SchedY), .SchedFire_i(SchedFire),
    .InitialX_i(InitialX), .InitialY_i(InitialY), .Hit_i(Hit), .FireAck_i(FireAck),
    .FireReq_o(FireReq), .FireX_o(FireX), .FireY_o(FireY),
    .ShipX_o(ShipX), .ShipY_o(ShipY), .Alive_o(Alive), .Exploding_o(Exploding)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // Model: 0 spawn, 1 active, 2 explode, 3 dead; cooldown tracked as cycles since last accepted fire.
  int cyc = 0, m_mode = 0, m_x = 0, m_y = 0, m_fx = 0, m_fy = 0, m_prev = 0, m_t = 0;
  int m_last = -100000;
  bit m_req = 1'b0;

  always @(posedge Clk) begin
    cyc = cyc + 1;
    if (Reset) begin
      m_mode = 0; m_x = 0; m_y = 0; m_req = 0; m_fx = 0; m_fy = 0; m_last = -100000;
    end else begin
      if (FireAck) m_req = 0;
      case (m_mode)
        0: begin
          m_x = int'(InitialX); m_y = int'(InitialY); m_prev = int'(ESchedCtr);
          m_last = -100000; m_mode = 1;
        end
        1: begin
          if (Hit) begin
            m_mode = 2; m_t = cyc; m_req = 0;
          end else if (int'(ESchedCtr) != m_prev && int'(ESchedCtr) < NM) begin
            m_x = clampi(m_x + t_dx[int'(ESchedCtr)], XMIN, XMAX);
            m_y = clampi(m_y + t_dy[int'(ESchedCtr)], YMIN, YMAX);
            if (t_f[int'(ESchedCtr)] && cyc - m_last > FIRE_COOLDOWN) begin
              m_req = 1; m_fx = m_x; m_fy = m_y; m_last = cyc;
            end
          end
          m_prev = int'(ESchedCtr);
        end
        2: if (cyc - m_t == EXPLODE_CYCLES) begin m_mode = 3; m_t = cyc; end
        default: begin
`ifdef ESHIP_RESPAWN_EN
          if (cyc - m_t == RESPAWN_CYCLES) m_mode = 0;
`endif
        end
      endcase
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("m_ShipX", 32'(ShipX), 32'(m_x));
      chk("m_ShipY", 32'(ShipY), 32'(m_y));
      chk("m_FireReq", 32'(FireReq), 32'(m_req));
      chk("m_FireX", 32'(FireX), 32'(m_fx));
      chk("m_FireY", 32'(FireY), 32'(m_fy));
      chk("m_Alive", 32'(Alive), 32'(m_mode == 1));
      chk("m_Exploding", 32'(Exploding), 32'(m_mode == 2));
    end
  end

  // Leaves the ship ACTIVE at InitialX/Y, sampled on a negedge.
  task automatic do_reset(input int ix, input int iy);
    Reset = 1; ESchedCtr = '0; Hit = 0; FireAck = 0;
    InitialX = 10'(ix); InitialY = 10'(iy);
    repeat (2) @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
  endtask

  initial begin
    int n_exp;
    for (int i = 0; i < NM; i++) begin
      t_dx[i] = 1; t_dy[i] = 0; t_f[i] = (i >= 12 && i <= 14);
    end
    Reset = 1; Hit = 0; FireAck = 0; ESchedCtr = '0; InitialX = 10'd100; InitialY = 10'd40;
    @(negedge Clk);
    chk_en = 1'b1;
    @(negedge Clk);
    chk("rst_ShipX", 32'(ShipX), 0);
    chk("rst_Alive", 32'(Alive), 0);
    chk("rst_FireReq", 32'(FireReq), 0);

    // Steady +1 X steps every two cycles, wrap back to step 0, fire window on 12..14.
    do_reset(100, 40);
    chk("spawn_Alive", 32'(Alive), 1);
    chk("spawn_ShipX", 32'(ShipX), 100);
    for (int k = 1; k <= 20; k++) begin
      ESchedCtr = 10'(k % 20);
      @(negedge Clk);
      chk("step_ShipX", 32'(ShipX), 32'(100 + k));
      if (k == 12) begin
        chk("fire_req", 32'(FireReq), 1);
        chk("fire_X", 32'(FireX), 112);
        chk("fire_Y", 32'(FireY), 40);
      end
      @(negedge Clk);
    end
    chk("wrap_ShipX", 32'(ShipX), 120);
    chk("held_req", 32'(FireReq), 1);
    chk("held_FireX", 32'(FireX), 112);
    FireAck = 1;
    @(negedge Clk);
    FireAck = 0;
    chk("ack_drop", 32'(FireReq), 0);
    ESchedCtr = 10'd25;
    repeat (2) @(negedge Clk);
    chk("oob_ShipX", 32'(ShipX), 120);

    // Clamp at both edges of the field.
    t_dx[1] = -3; t_dy[1] = 3;
    do_reset(2, 458);
    ESchedCtr = 10'd1;
    @(negedge Clk);
    chk("clamp_lo_X", 32'(ShipX), 0);
    chk("clamp_hi_Y", 32'(ShipY), 460);
    t_dx[1] = 3; t_dy[1] = -3;
    do_reset(619, 1);
    ESchedCtr = 10'd1;
    @(negedge Clk);
    chk("clamp_hi_X", 32'(ShipX), 620);
    chk("clamp_lo_Y", 32'(ShipY), 0);
    t_dx[1] = 1; t_dy[1] = 0;

    // Reset while a request is pending.
    do_reset(100, 40);
    ESchedCtr = 10'd12;
    @(negedge Clk);
    chk("pre_rst_req", 32'(FireReq), 1);
    chk("pre_rst_FireX", 32'(FireX), 101);
    Reset = 1;
    @(negedge Clk);
    chk("mid_rst_req", 32'(FireReq), 0);
    chk("mid_rst_ShipX", 32'(ShipX), 0);
    chk("mid_rst_FireX", 32'(FireX), 0);
    chk("mid_rst_Alive", 32'(Alive), 0);

    // Hit kills an outstanding request without an acknowledge.
    do_reset(100, 40);
    ESchedCtr = 10'd12;
    @(negedge Clk);
    Hit = 1;
    @(negedge Clk);
    Hit = 0;
    chk("kill_req", 32'(FireReq), 0);
    chk("kill_expl", 32'(Exploding), 1);

    // Hit coincident with a fire step, full explosion, then DEAD.
    do_reset(100, 40);
    ESchedCtr = 10'd12; Hit = 1;
    @(negedge Clk);
    Hit = 0;
    chk("hitfire_req", 32'(FireReq), 0);
    chk("hitfire_ShipX", 32'(ShipX), 100);
    n_exp = 0;
    for (int i = 0; i < 40; i++) begin
      if (Exploding) n_exp++;
      @(negedge Clk);
    end
    chk("expl_cycles", 32'(n_exp), 32);
    chk("dead_Alive", 32'(Alive), 0);
    chk("dead_Expl", 32'(Exploding), 0);
    Hit = 1;
    @(negedge Clk);
    Hit = 0;
    chk("dead_hit_ignored", 32'(Exploding), 0);
`ifdef ESHIP_RESPAWN_EN
    repeat (1100) @(negedge Clk);
    chk("respawn_Alive", 32'(Alive), 1);
    chk("respawn_ShipX", 32'(ShipX), 100);
    chk("respawn_ShipY", 32'(ShipY), 40);
`else
    repeat (5000) @(negedge Clk);
    chk("still_dead_Alive", 32'(Alive), 0);
    chk("still_dead_Expl", 32'(Exploding), 0);
`endif

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
